// File: rtl/tod_clock_12h.sv
// 12-hour BCD time-of-day clock with a run-gated prescaler, a validated time-load
// port, and registered second/hour strobes.
module tod_clock_12h #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_minutes,
  input  logic       set_pm,
  output logic       set_ready,
  output logic       set_err,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       pm,
  output logic       sec_pulse,
  output logic       hour_pulse
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hours_q, hours_d;
  logic [7:0]    minutes_q, minutes_d;
  logic [7:0]    seconds_q, seconds_d;
  logic          pm_q, pm_d;
  logic          set_ready_q, set_ready_d;
  logic          set_err_q, set_err_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          hour_pulse_q, hour_pulse_d;

  logic tick;
  logic set_ok;
  logic accept;
  logic reject;

  // Increment a BCD value in 00..59, wrapping 59 -> 00.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Increment a BCD hour along 12 -> 01 -> ... -> 11 -> 12.
  function automatic logic [7:0] hour_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h12)            r = 8'h01;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    set_ok = 1'b0;
    // Hour must be 01..09 or 10..12; minute tens 0..5 with a decimal units digit.
    if (((set_hours[7:4] == 4'd0) && (set_hours[3:0] >= 4'd1) && (set_hours[3:0] <= 4'd9)) ||
        ((set_hours[7:4] == 4'd1) && (set_hours[3:0] <= 4'd2))) begin
      if ((set_minutes[7:4] <= 4'd5) && (set_minutes[3:0] <= 4'd9))
        set_ok = 1'b1;
    end
  end

  assign tick   = run && (presc_q == TERM);
  assign accept = set_valid && set_ready_q && set_ok;
  assign reject = set_valid && set_ready_q && !set_ok;

  always_comb begin
    presc_d      = presc_q;
    hours_d      = hours_q;
    minutes_d    = minutes_q;
    seconds_d    = seconds_q;
    pm_d         = pm_q;
    set_ready_d  = 1'b1;
    set_err_d    = 1'b0;
    sec_pulse_d  = 1'b0;
    hour_pulse_d = 1'b0;

    if (accept) begin
      // A load overrides a coincident tick entirely.
      hours_d     = set_hours;
      minutes_d   = set_minutes;
      pm_d        = set_pm;
      seconds_d   = 8'h00;
      presc_d     = '0;
      set_ready_d = 1'b0;
    end else begin
      set_err_d = reject;
      if (tick) begin
        presc_d     = '0;
        sec_pulse_d = 1'b1;
        seconds_d   = bcd_inc60(seconds_q);
        if (seconds_q == 8'h59) begin
          minutes_d = bcd_inc60(minutes_q);
          if (minutes_q == 8'h59) begin
            hour_pulse_d = 1'b1;
            hours_d      = hour_inc(hours_q);
            if (hours_q == 8'h11) pm_d = ~pm_q;
          end
        end
      end else if (run) begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      hours_q      <= 8'h12;
      minutes_q    <= 8'h00;
      seconds_q    <= 8'h00;
      pm_q         <= 1'b0;
      set_ready_q  <= 1'b1;
      set_err_q    <= 1'b0;
      sec_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      pm_q         <= pm_d;
      set_ready_q  <= set_ready_d;
      set_err_q    <= set_err_d;
      sec_pulse_q  <= sec_pulse_d;
      hour_pulse_q <= hour_pulse_d;
    end
  end

  assign hours      = hours_q;
  assign minutes    = minutes_q;
  assign seconds    = seconds_q;
  assign pm         = pm_q;
  assign set_ready  = set_ready_q;
  assign set_err    = set_err_q;
  assign sec_pulse  = sec_pulse_q;
  assign hour_pulse = hour_pulse_q;

endmodule

// File: tb/tb_tod_clock_12h.sv
// Directed bench for tod_clock_12h with TICKS_PER_SEC=4; one initial block of
// linear steps, each comparison an immediate assertion.
module tb_tod_clock_12h;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       set_valid;
  logic [7:0] set_hours;
  logic [7:0] set_minutes;
  logic       set_pm;
  logic       set_ready;
  logic       set_err;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       pm;
  logic       sec_pulse;
  logic       hour_pulse;

  int checks   = 0;
  int failures = 0;
  int sp_cnt   = 0;
  int hp_cnt   = 0;

  tod_clock_12h #(.TICKS_PER_SEC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .set_valid  (set_valid),
    .set_hours  (set_hours),
    .set_minutes(set_minutes),
    .set_pm     (set_pm),
    .set_ready  (set_ready),
    .set_err    (set_err),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .pm         (pm),
    .sec_pulse  (sec_pulse),
    .hour_pulse (hour_pulse)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (sec_pulse === 1'b1)  sp_cnt++;
    if (hour_pulse === 1'b1) hp_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input logic p);
    chk8({tag, "_hours"}, hours, h);
    chk8({tag, "_minutes"}, minutes, m);
    chk8({tag, "_seconds"}, seconds, s);
    chk1({tag, "_pm"}, pm, p);
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic p);
    set_hours   = h;
    set_minutes = m;
    set_pm      = p;
    set_valid   = 1'b1;
    step();
    set_valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; set_valid = 1'b0;
    set_hours = 8'h00; set_minutes = 8'h00; set_pm = 1'b0;

    // Reset state
    steps(2);
    rst = 1'b0;
    chk_time("reset", 8'h12, 8'h00, 8'h00, 1'b0);
    chk1("reset_set_ready", set_ready, 1'b1);
    chk1("reset_set_err", set_err, 1'b0);
    chk1("reset_sec_pulse", sec_pulse, 1'b0);
    chk1("reset_hour_pulse", hour_pulse, 1'b0);
    $display("txn reset: %h:%h:%h pm=%b", hours, minutes, seconds, pm);

    // Scenario 1: pulses on run cycles 4 and 8
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk1($sformatf("s1_sec_pulse_c%0d", c), sec_pulse, (c == 4 || c == 8));
    end
    run = 1'b0;
    chk8("s1_seconds", seconds, 8'h02);
    $display("txn run8: seconds=%h", seconds);

    // Scenario 3: three rejected loads
    load(8'h13, 8'h00, 1'b0);
    chk1("s3a_set_err", set_err, 1'b1);
    chk_time("s3a", 8'h12, 8'h00, 8'h02, 1'b0);
    step();
    chk1("s3a_err_clear", set_err, 1'b0);
    $display("txn reject 13:00 err_seen");
    load(8'h00, 8'h00, 1'b1);
    chk1("s3b_set_err", set_err, 1'b1);
    chk_time("s3b", 8'h12, 8'h00, 8'h02, 1'b0);
    step();
    $display("txn reject 00:00 err_seen");
    load(8'h05, 8'h5A, 1'b0);
    chk1("s3c_set_err", set_err, 1'b1);
    chk1("s3c_set_ready", set_ready, 1'b1);
    chk_time("s3c", 8'h12, 8'h00, 8'h02, 1'b0);
    step();
    $display("txn reject 05:5A err_seen");

    // Scenario 2: 11:59 AM -> 12:00:00 PM -> 01:00:00 PM
    load(8'h11, 8'h59, 1'b0);
    chk_time("s2_load", 8'h11, 8'h59, 8'h00, 1'b0);
    chk1("s2_load_ready", set_ready, 1'b0);
    chk1("s2_load_pulse", sec_pulse, 1'b0);
    run = 1'b1;
    sp_cnt = 0; hp_cnt = 0;
    steps(240);
    chk_time("s2_noon", 8'h12, 8'h00, 8'h00, 1'b1);
    chki("s2_noon_sec_pulses", sp_cnt, 60);
    chki("s2_noon_hour_pulses", hp_cnt, 1);
    $display("txn run60s: %h:%h:%h pm=%b", hours, minutes, seconds, pm);
    sp_cnt = 0; hp_cnt = 0;
    steps(14400);
    run = 1'b0;
    chk_time("s2_one", 8'h01, 8'h00, 8'h00, 1'b1);
    chki("s2_one_hour_pulses", hp_cnt, 1);
    $display("txn run3600s: %h:%h:%h pm=%b", hours, minutes, seconds, pm);

    // Scenario 4: set_valid held two cycles
    set_hours = 8'h07; set_minutes = 8'h30; set_pm = 1'b1; set_valid = 1'b1;
    step();
    chk1("s4_ready_low", set_ready, 1'b0);
    chk1("s4_err1", set_err, 1'b0);
    chk_time("s4", 8'h07, 8'h30, 8'h00, 1'b1);
    set_hours = 8'h13;
    step();
    set_valid = 1'b0;
    chk1("s4_ready_back", set_ready, 1'b1);
    chk1("s4_err2", set_err, 1'b0);
    chk_time("s4_after", 8'h07, 8'h30, 8'h00, 1'b1);
    $display("txn hold2 07:30PM: %h:%h:%h pm=%b", hours, minutes, seconds, pm);

    // Scenario 5: valid load on the tick cycle
    run = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk1($sformatf("s5_pre_pulse_c%0d", c), sec_pulse, 1'b0);
    end
    load(8'h10, 8'h45, 1'b0);
    chk_time("s5_load", 8'h10, 8'h45, 8'h00, 1'b0);
    chk1("s5_load_pulse", sec_pulse, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk1($sformatf("s5_post_pulse_c%0d", c), sec_pulse, (c == 4));
    end
    chk8("s5_seconds", seconds, 8'h01);
    $display("txn load_on_tick 10:45: %h:%h:%h", hours, minutes, seconds);

    // Scenario 6: reset mid-count at 05:17:42 PM
    run = 1'b0;
    load(8'h05, 8'h17, 1'b1);
    run = 1'b1;
    steps(168);
    chk_time("s6_pre", 8'h05, 8'h17, 8'h42, 1'b1);
    steps(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_time("s6_rst", 8'h12, 8'h00, 8'h00, 1'b0);
    chk1("s6_rst_ready", set_ready, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk1($sformatf("s6_pulse_c%0d", c), sec_pulse, (c == 4));
    end
    $display("txn reset_midcount: %h:%h:%h pm=%b", hours, minutes, seconds, pm);

    // Rejected load coincident with a tick: tick still advances time
    steps(3);
    load(8'h13, 8'h00, 1'b0);
    chk1("rt_set_err", set_err, 1'b1);
    chk1("rt_sec_pulse", sec_pulse, 1'b1);
    chk_time("rt", 8'h12, 8'h00, 8'h02, 1'b0);
    $display("txn reject_on_tick: %h:%h:%h err=%b", hours, minutes, seconds, set_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
